// File: rtl/stream_upsize_arbiter.sv
// Packet-level round-robin arbiter feeding one stream_upsize from N_PORTS narrow requesters.
// Define STREAM_UPSIZE_ARB_STATS_EN to add per-port completed-packet counters (pkt_cnt_o).
module stream_upsize_arbiter #(
  parameter int T_DATA_WIDTH = 8,
  parameter int N_PORTS      = 4,
  parameter int ID_WIDTH     = $clog2(N_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_PORTS-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [N_PORTS-1:0]                   s_last_i,
  input  logic [N_PORTS-1:0]                   s_valid_i,
  output logic [N_PORTS-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]              m_data_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i,
  output logic [ID_WIDTH-1:0]                  m_id_o,
  output logic                                 busy_o
`ifdef STREAM_UPSIZE_ARB_STATS_EN
  ,
  output logic [N_PORTS-1:0][15:0]             pkt_cnt_o
`endif
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rrPtr_q, rrPtr_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [T_DATA_WIDTH-1:0] mData_q, mData_d;
  logic                    mLast_q, mLast_d;
  logic                    mValid_q, mValid_d;
  logic [ID_WIDTH-1:0]     mId_q, mId_d;

  logic                    found;
  logic [ID_WIDTH-1:0]     winner;
  logic [ID_WIDTH-1:0]     nextPtr;
  logic                    sliceReady;
  logic                    accept;

  // First valid port at or after rrPtr, wrapping modulo N_PORTS.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = rrPtr_q;
    idx    = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(rrPtr_q) + i) % N_PORTS;
      if (!found && s_valid_i[idx]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(idx);
      end
    end
  end

  assign nextPtr    = (int'(grant_q) == N_PORTS - 1) ? '0 : grant_q + ID_WIDTH'(1);
  assign sliceReady = !mValid_q || m_ready_i;
  assign accept     = (state_q == LOCK) && s_valid_i[grant_q] && sliceReady;

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    mData_d   = mData_q;
    mLast_d   = mLast_q;
    mValid_d  = mValid_q;
    mId_d     = mId_q;
    s_ready_o = '0;

    if (m_ready_i) begin
      mValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = LOCK;
        end
      end
      LOCK: begin
        s_ready_o[grant_q] = sliceReady;
        // Only the granted port's data is ever sampled, so X elsewhere cannot leak.
        if (accept) begin
          mData_d  = s_data_i[grant_q];
          mLast_d  = s_last_i[grant_q];
          mId_d    = grant_q;
          mValid_d = 1'b1;
          if (s_last_i[grant_q]) begin
            state_d = IDLE;
            rrPtr_d = nextPtr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rrPtr_q  <= '0;
      grant_q  <= '0;
      mData_q  <= '0;
      mLast_q  <= 1'b0;
      mValid_q <= 1'b0;
      mId_q    <= '0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      grant_q  <= grant_d;
      mData_q  <= mData_d;
      mLast_q  <= mLast_d;
      mValid_q <= mValid_d;
      mId_q    <= mId_d;
    end
  end

  assign m_data_o  = mData_q;
  assign m_last_o  = mLast_q;
  assign m_valid_o = mValid_q;
  assign m_id_o    = mId_q;
  assign busy_o    = (state_q == LOCK);

`ifdef STREAM_UPSIZE_ARB_STATS_EN
  logic [N_PORTS-1:0][15:0] pktCnt_q;

  // Counts completed packets per source; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pktCnt_q <= '0;
    end else if (accept && s_last_i[grant_q]) begin
      pktCnt_q[grant_q] <= pktCnt_q[grant_q] + 16'd1;
    end
  end

  assign pkt_cnt_o = pktCnt_q;
`endif

endmodule
